// File: rtl/conv2d_event_accum_if.sv
// conv2d_event_accum_if: spike-event handshake between the capture stage and the engine.
interface conv2d_event_accum_if #(
    parameter int COORD_BITS  = 8,
    parameter int IN_CHANNELS = 4
);
    logic                   evt_valid;
    logic                   evt_ready;
    logic [COORD_BITS-1:0]  evt_x;
    logic [COORD_BITS-1:0]  evt_y;
    logic [IN_CHANNELS-1:0] evt_spikes;

    modport master (output evt_valid, evt_x, evt_y, evt_spikes, input evt_ready);
    modport slave  (input evt_valid, evt_x, evt_y, evt_spikes, output evt_ready);
endinterface

// File: rtl/conv2d_event_accum.sv
// conv2d_event_accum: event-driven 2D convolution, one read-modify-write per kernel position.
// Optional build macro CONV_ACCUM_SATURATE_EN: clamp neuron sums instead of wrapping.
//
// state | meaning
// IDLE  | ready for an event; out-of-range events are dropped with evt_err
// LOAD  | compact active channels, seed the first in-bounds kernel position
// ACCUM | one weight fetch per active channel; neuron read on the first cycle
// WRITE | fold in the last weight, write the neuron word, step position
// DONE  | one-cycle completion pulse
module conv2d_event_accum #(
    parameter int COORD_BITS      = 8,
    parameter int IMG_WIDTH       = 32,
    parameter int IMG_HEIGHT      = 32,
    parameter int IN_CHANNELS     = 4,
    parameter int OUT_CHANNELS    = 8,
    parameter int KERNEL_SIZE     = 3,
    parameter int BITS_PER_WEIGHT = 4,
    parameter int BITS_PER_NEURON = 9
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    conv2d_event_accum_if.slave                           evt,
    output logic                                          kb_en,
    output logic [$clog2(IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE)-1:0] kb_addr,
    input  logic [OUT_CHANNELS*BITS_PER_WEIGHT-1:0]       kb_data,
    output logic                                          fm_rd_en,
    output logic [COORD_BITS-1:0]                         fm_rd_x,
    output logic [COORD_BITS-1:0]                         fm_rd_y,
    input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]       fm_rd_data,
    output logic                                          fm_wr_en,
    output logic [COORD_BITS-1:0]                         fm_wr_x,
    output logic [COORD_BITS-1:0]                         fm_wr_y,
    output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]       fm_wr_data,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          evt_err
);
    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int HALF  = KERNEL_SIZE / 2;
    localparam int KB_AW = $clog2(IN_CHANNELS * KK);
    localparam int KW    = $clog2(KERNEL_SIZE + 1);
    localparam int CW    = $clog2(IN_CHANNELS + 1);
    localparam int CHW   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int ACC_W = BITS_PER_WEIGHT + $clog2(IN_CHANNELS) + 1;
    localparam int BW    = BITS_PER_WEIGHT;
    localparam int NB    = BITS_PER_NEURON;
    localparam logic [COORD_BITS:0] HALF_E = (COORD_BITS+1)'(HALF);
    localparam logic [COORD_BITS:0] W_LAST = (COORD_BITS+1)'(IMG_WIDTH - 1);
    localparam logic [COORD_BITS:0] H_LAST = (COORD_BITS+1)'(IMG_HEIGHT - 1);
    localparam logic [COORD_BITS:0] W_LIM  = (COORD_BITS+1)'(IMG_WIDTH);
    localparam logic [COORD_BITS:0] H_LIM  = (COORD_BITS+1)'(IMG_HEIGHT);
`ifdef CONV_ACCUM_SATURATE_EN
    localparam int SUM_W = NB + ACC_W;
    localparam logic signed [SUM_W-1:0] N_MAX = SUM_W'(2**(NB-1) - 1);
    localparam logic signed [SUM_W-1:0] N_MIN = SUM_W'(-(2**(NB-1)));
    logic signed [SUM_W-1:0] sum;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCUM, S_WRITE, S_DONE} state_t;
    state_t state_q, state_d;

    logic [COORD_BITS-1:0]  x_q, x_d, y_q, y_d;
    logic [IN_CHANNELS-1:0] spk_q, spk_d;
    logic                   err_q, err_d, rd_vld_q, rd_vld_d;
    logic [CHW-1:0]         act_q [IN_CHANNELS];
    logic [CHW-1:0]         act_d [IN_CHANNELS];
    logic [CHW-1:0]         act_c [IN_CHANNELS];
    logic [CW-1:0]          n_act_q, n_act_d, n_act_c, i_q, i_d;
    logic [KW-1:0]          kx_q, kx_d, ky_q, ky_d, kx_lo, kx_hi, ky_lo, ky_hi;
    logic signed [ACC_W-1:0] acc_q [OUT_CHANNELS];
    logic signed [ACC_W-1:0] acc_d [OUT_CHANNELS];
    logic signed [ACC_W-1:0] acc_fin [OUT_CHANNELS];
    logic signed [NB-1:0]   nrn_q [OUT_CHANNELS];
    logic signed [NB-1:0]   nrn_d [OUT_CHANNELS];
    logic signed [NB-1:0]   nrn_src [OUT_CHANNELS];
    logic signed [BW-1:0]   wt [OUT_CHANNELS];
    logic [NB-1:0]          res [OUT_CHANNELS];
    logic                   oob_c, last_ch, last_pos;
    logic [COORD_BITS-1:0]  pos_x, pos_y;

    // In-bounds kernel positions form a rectangle; derive its limits from the latched centre.
    always_comb begin
        kx_lo = ({1'b0, x_q} < HALF_E) ? KW'(HALF_E - {1'b0, x_q}) : '0;
        ky_lo = ({1'b0, y_q} < HALF_E) ? KW'(HALF_E - {1'b0, y_q}) : '0;
        kx_hi = ({1'b0, x_q} + HALF_E > W_LAST) ? KW'(W_LAST + HALF_E - {1'b0, x_q}) : KW'(KERNEL_SIZE - 1);
        ky_hi = ({1'b0, y_q} + HALF_E > H_LAST) ? KW'(H_LAST + HALF_E - {1'b0, y_q}) : KW'(KERNEL_SIZE - 1);
        pos_x = x_q + COORD_BITS'(kx_q) - COORD_BITS'(HALF);
        pos_y = y_q + COORD_BITS'(ky_q) - COORD_BITS'(HALF);
        oob_c = ({1'b0, evt.evt_x} >= W_LIM) || ({1'b0, evt.evt_y} >= H_LIM);
        last_ch  = (i_q == n_act_q - CW'(1));
        last_pos = (kx_q == kx_hi) && (ky_q == ky_hi);
    end

    // Compact the spike mask into a list of active channel indices.
    always_comb begin
        n_act_c = '0;
        for (int c = 0; c < IN_CHANNELS; c++) act_c[c] = '0;
        for (int c = 0; c < IN_CHANNELS; c++) begin
            if (spk_q[c]) begin
                act_c[CHW'(n_act_c)] = CHW'(c);
                n_act_c = n_act_c + CW'(1);
            end
        end
    end

    // Per-lane weight accumulation and neuron update arithmetic.
    always_comb begin
`ifdef CONV_ACCUM_SATURATE_EN
        sum = '0;
`endif
        for (int j = 0; j < OUT_CHANNELS; j++) begin
            wt[j]      = kb_data[j*BW +: BW];
            nrn_src[j] = rd_vld_q ? fm_rd_data[j*NB +: NB] : nrn_q[j];
            acc_fin[j] = acc_q[j] + ACC_W'(wt[j]);
`ifdef CONV_ACCUM_SATURATE_EN
            sum = SUM_W'(nrn_src[j]) + SUM_W'(acc_fin[j]);
            if (sum > N_MAX)      res[j] = N_MAX[NB-1:0];
            else if (sum < N_MIN) res[j] = N_MIN[NB-1:0];
            else                  res[j] = sum[NB-1:0];
`else
            res[j] = nrn_src[j] + NB'(acc_fin[j]);
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (evt.evt_valid && !oob_c) state_d = S_LOAD;
            S_LOAD:  state_d = (n_act_c == '0) ? S_DONE : S_ACCUM;
            S_ACCUM: if (last_ch) state_d = S_WRITE;
            S_WRITE: state_d = last_pos ? S_DONE : S_ACCUM;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0; y_q <= '0; spk_q <= '0; err_q <= 1'b0; rd_vld_q <= 1'b0;
            n_act_q <= '0; i_q <= '0; kx_q <= '0; ky_q <= '0;
            for (int c = 0; c < IN_CHANNELS; c++) act_q[c] <= '0;
            for (int j = 0; j < OUT_CHANNELS; j++) begin
                acc_q[j] <= '0;
                nrn_q[j] <= '0;
            end
        end else begin
            x_q <= x_d; y_q <= y_d; spk_q <= spk_d; err_q <= err_d; rd_vld_q <= rd_vld_d;
            n_act_q <= n_act_d; i_q <= i_d; kx_q <= kx_d; ky_q <= ky_d;
            act_q <= act_d; acc_q <= acc_d; nrn_q <= nrn_d;
        end
    end

    // Datapath next values: event latch, channel/position stepping, accumulation.
    always_comb begin
        x_d = x_q; y_d = y_q; spk_d = spk_q; err_d = 1'b0; rd_vld_d = 1'b0;
        act_d = act_q; n_act_d = n_act_q; i_d = i_q; kx_d = kx_q; ky_d = ky_q;
        acc_d = acc_q;
        nrn_d = nrn_src;
        case (state_q)
            S_IDLE: begin
                if (evt.evt_valid) begin
                    x_d   = evt.evt_x;
                    y_d   = evt.evt_y;
                    spk_d = evt.evt_spikes;
                    err_d = oob_c;
                end
            end
            S_LOAD: begin
                act_d   = act_c;
                n_act_d = n_act_c;
                i_d     = '0;
                kx_d    = kx_lo;
                ky_d    = ky_lo;
            end
            S_ACCUM: begin
                // Weight data lags its fetch by one cycle, so cycle 0 only clears.
                rd_vld_d = (i_q == '0);
                for (int j = 0; j < OUT_CHANNELS; j++)
                    acc_d[j] = (i_q == '0) ? '0 : acc_fin[j];
                i_d = last_ch ? '0 : i_q + CW'(1);
            end
            S_WRITE: begin
                if (kx_q == kx_hi) begin
                    kx_d = kx_lo;
                    ky_d = ky_q + KW'(1);
                end else begin
                    kx_d = kx_q + KW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        evt.evt_ready = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        evt_err       = err_q;
        kb_en = 1'b0; kb_addr = '0;
        fm_rd_en = 1'b0; fm_rd_x = '0; fm_rd_y = '0;
        fm_wr_en = 1'b0; fm_wr_x = '0; fm_wr_y = '0; fm_wr_data = '0;
        case (state_q)
            S_ACCUM: begin
                kb_en   = 1'b1;
                kb_addr = KB_AW'(act_q[CHW'(i_q)]) * KB_AW'(KK)
                        + KB_AW'(ky_q) * KB_AW'(KERNEL_SIZE) + KB_AW'(kx_q);
                if (i_q == '0) begin
                    fm_rd_en = 1'b1;
                    fm_rd_x  = pos_x;
                    fm_rd_y  = pos_y;
                end
            end
            S_WRITE: begin
                fm_wr_en = 1'b1;
                fm_wr_x  = pos_x;
                fm_wr_y  = pos_y;
                for (int j = 0; j < OUT_CHANNELS; j++) fm_wr_data[j*NB +: NB] = res[j];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_conv2d_event_accum.sv
// tb_conv2d_event_accum: directed checks of the event convolution engine with
// behavioural kernel BRAM and feature-map memories.
module tb_conv2d_event_accum;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kb_en;
    logic [5:0]  kb_addr;
    logic [31:0] kb_data = '0;
    logic        fm_rd_en;
    logic [7:0]  fm_rd_x, fm_rd_y;
    logic [71:0] fm_rd_data = '0;
    logic        fm_wr_en;
    logic [7:0]  fm_wr_x, fm_wr_y;
    logic [71:0] fm_wr_data;
    logic        busy, done, evt_err;

    logic [31:0] kmem [64];
    logic [71:0] fmem [32][32];
    logic        clr = 1'b0, pre_we = 1'b0;
    logic [4:0]  pre_x = '0, pre_y = '0;
    logic [71:0] pre_d = '0;

    int kb_log[$];
    int rd_cnt = 0, wr_cnt = 0;
    int n_vec = 0, n_err = 0;

    conv2d_event_accum_if #(.COORD_BITS(8), .IN_CHANNELS(4)) evt_if ();

    conv2d_event_accum #(
        .COORD_BITS(8), .IMG_WIDTH(32), .IMG_HEIGHT(32), .IN_CHANNELS(4),
        .OUT_CHANNELS(8), .KERNEL_SIZE(3), .BITS_PER_WEIGHT(4), .BITS_PER_NEURON(9)
    ) dut (
        .clk(clk), .rst_n(rst_n), .evt(evt_if),
        .kb_en(kb_en), .kb_addr(kb_addr), .kb_data(kb_data),
        .fm_rd_en(fm_rd_en), .fm_rd_x(fm_rd_x), .fm_rd_y(fm_rd_y), .fm_rd_data(fm_rd_data),
        .fm_wr_en(fm_wr_en), .fm_wr_x(fm_wr_x), .fm_wr_y(fm_wr_y), .fm_wr_data(fm_wr_data),
        .busy(busy), .done(done), .evt_err(evt_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (kb_en) kb_data <= kmem[kb_addr];
        if (fm_rd_en) fm_rd_data <= fmem[fm_rd_y[4:0]][fm_rd_x[4:0]];
        if (clr) begin
            for (int yy = 0; yy < 32; yy++)
                for (int xx = 0; xx < 32; xx++) fmem[yy][xx] <= '0;
        end else if (pre_we) begin
            fmem[pre_y][pre_x] <= pre_d;
        end else if (fm_wr_en) begin
            fmem[fm_wr_y[4:0]][fm_wr_x[4:0]] <= fm_wr_data;
        end
    end

    always @(negedge clk) begin
        if (kb_en) kb_log.push_back(int'(kb_addr));
        if (fm_rd_en) rd_cnt++;
        if (fm_wr_en) wr_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wfun(input int a, input int j);
        return ((a * 3 + j * 5) % 16) - 8;
    endfunction

    task automatic fill_k(input logic [3:0] w);
        for (int a = 0; a < 64; a++) kmem[a] = {8{w}};
    endtask

    task automatic preload(input int x, input int y, input logic [71:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_x = 5'(x); pre_y = 5'(y); pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic send(input int x, input int y, input logic [3:0] s);
        @(negedge clk);
        evt_if.evt_valid = 1'b1; evt_if.evt_x = 8'(x); evt_if.evt_y = 8'(y); evt_if.evt_spikes = s;
        @(negedge clk);
        evt_if.evt_valid = 1'b0;
    endtask

    // Returns the cycle index (accept cycle = 0) at which done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc, kb_base, rd_base, wr_base, v, kidx;
        int seq2 [16];
        int seq6 [8];
        logic [71:0] e, init_w;

        evt_if.evt_valid = 1'b0; evt_if.evt_x = '0; evt_if.evt_y = '0; evt_if.evt_spikes = '0;
        clr = 1'b1;
        #12;
        check("rst_ready", evt_if.evt_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", evt_err, 0);
        check("rst_kb_en", kb_en, 0);
        check("rst_rd_en", fm_rd_en, 0);
        check("rst_wr_en", fm_wr_en, 0);
        check("rst_kb_addr", kb_addr, 0);
        @(negedge clk);
        clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", evt_if.evt_ready, 1);

        // Centre event, one channel, unit weights.
        fill_k(4'h1);
        kb_base = kb_log.size(); rd_base = rd_cnt; wr_base = wr_cnt;
        send(16, 16, 4'b0001);
        wait_done(cyc);
        check("t1_latency", cyc, 20);
        repeat (2) @(negedge clk);
        check("t1_writes", wr_cnt - wr_base, 9);
        check("t1_reads", rd_cnt - rd_base, 9);
        check("t1_kb_count", kb_log.size() - kb_base, 9);
        for (int i = 0; i < 9; i++)
            check("t1_kb_addr", (kb_base + i < kb_log.size()) ? kb_log[kb_base + i] : -1, i);
        for (int yy = 15; yy <= 17; yy++)
            for (int xx = 15; xx <= 17; xx++)
                check("t1_word", fmem[yy][xx], {8{9'd1}});
        check("t1_outside", fmem[16][14], 0);
        check("t1_outside2", fmem[18][16], 0);

        // Top-left corner, all channels, weight +2.
        fill_k(4'h2);
        seq2 = '{4, 13, 22, 31, 5, 14, 23, 32, 7, 16, 25, 34, 8, 17, 26, 35};
        kb_base = kb_log.size(); wr_base = wr_cnt;
        send(0, 0, 4'b1111);
        wait_done(cyc);
        check("t2_latency", cyc, 22);
        repeat (2) @(negedge clk);
        check("t2_writes", wr_cnt - wr_base, 4);
        check("t2_kb_count", kb_log.size() - kb_base, 16);
        for (int i = 0; i < 16; i++)
            check("t2_kb_addr", (kb_base + i < kb_log.size()) ? kb_log[kb_base + i] : -1, seq2[i]);
        check("t2_w00", fmem[0][0], {8{9'd8}});
        check("t2_w10", fmem[0][1], {8{9'd8}});
        check("t2_w01", fmem[1][0], {8{9'd8}});
        check("t2_w11", fmem[1][1], {8{9'd8}});
        check("t2_w20", fmem[0][2], 0);

        // Empty spike mask: no memory traffic.
        kb_base = kb_log.size(); rd_base = rd_cnt; wr_base = wr_cnt;
        send(5, 5, 4'b0000);
        wait_done(cyc);
        check("t3_latency", cyc, 2);
        repeat (2) @(negedge clk);
        check("t3_kb", kb_log.size() - kb_base, 0);
        check("t3_rd", rd_cnt - rd_base, 0);
        check("t3_wr", wr_cnt - wr_base, 0);

        // Out-of-bounds event is accepted and dropped.
        kb_base = kb_log.size(); rd_base = rd_cnt; wr_base = wr_cnt;
        send(40, 3, 4'b0001);
        check("t4_err_pulse", evt_err, 1);
        check("t4_ready", evt_if.evt_ready, 1);
        check("t4_busy", busy, 0);
        @(negedge clk);
        check("t4_err_clear", evt_err, 0);
        repeat (4) @(negedge clk);
        check("t4_kb", kb_log.size() - kb_base, 0);
        check("t4_rd", rd_cnt - rd_base, 0);
        check("t4_wr", wr_cnt - wr_base, 0);

        // Bottom-right corner, channels 0 and 2, per-lane signed weights.
        for (int a = 0; a < 64; a++)
            for (int j = 0; j < 8; j++) kmem[a][j*4 +: 4] = 4'(wfun(a, j));
        for (int j = 0; j < 8; j++) init_w[j*9 +: 9] = 9'(j * 20 - 70);
        preload(30, 30, init_w); preload(31, 30, init_w);
        preload(30, 31, init_w); preload(31, 31, init_w);
        seq6 = '{0, 18, 1, 19, 3, 21, 4, 22};
        kb_base = kb_log.size(); wr_base = wr_cnt;
        send(31, 31, 4'b0101);
        wait_done(cyc);
        check("t6_latency", cyc, 14);
        repeat (2) @(negedge clk);
        check("t6_writes", wr_cnt - wr_base, 4);
        for (int i = 0; i < 8; i++)
            check("t6_kb_addr", (kb_base + i < kb_log.size()) ? kb_log[kb_base + i] : -1, seq6[i]);
        for (int dy = -1; dy <= 0; dy++)
            for (int dx = -1; dx <= 0; dx++) begin
                kidx = (dy + 1) * 3 + (dx + 1);
                for (int j = 0; j < 8; j++) begin
                    v = j * 20 - 70 + wfun(kidx, j) + wfun(18 + kidx, j);
                    e[j*9 +: 9] = 9'(v);
                end
                check("t6_word", fmem[31 + dy][31 + dx], e);
            end

        // Overflow: 250 + 4*7 = 278 exceeds the 9-bit signed range.
        fill_k(4'h7);
        preload(10, 10, {8{9'd250}});
        send(10, 10, 4'b1111);
        wait_done(cyc);
        check("t5_latency", cyc, 47);
        repeat (2) @(negedge clk);
`ifdef CONV_ACCUM_SATURATE_EN
        check("t5_centre", fmem[10][10], {8{9'h0FF}});
`else
        check("t5_centre", fmem[10][10], {8{9'h116}});
`endif
        check("t5_neighbour", fmem[10][9], {8{9'd28}});

        // Reset asserted while accumulating.
        send(20, 20, 4'b1111);
        @(negedge clk);
        check("t7_in_accum", kb_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_kb_en", kb_en, 0);
        check("t7_rd_en", fm_rd_en, 0);
        check("t7_wr_en", fm_wr_en, 0);
        check("t7_ready", evt_if.evt_ready, 1);
        check("t7_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_base = wr_cnt;
        repeat (60) @(negedge clk);
        check("t7_no_write", wr_cnt - wr_base, 0);
        check("t7_map_intact", fmem[20][20], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
